updown_counter_mc: RTL and testbench
====================================

UPDOWN_COUNTER_MC -- requirements
Module: updown_counter_mc

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each channel count, legal 2..32.
REQ-002 Parameter CHANNELS, default 4: number of independent counter channels, legal 1..16.
REQ-003 Parameter MAX_COUNT, default 2**WIDTH-1: upper terminal value of every channel; legal 1..2**WIDTH-1.
REQ-004 Parameter MODE, default WRAP: overflow policy, WRAP or SATURATE (package enum).
REQ-005 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset of all channels.
REQ-008 inc  input  CHANNELS  per-channel increment request.
REQ-009 dec  input  CHANNELS  per-channel decrement request.
REQ-010 load  input  1  load strobe for the channel selected by load_ch.
REQ-011 load_ch  input  clog2(CHANNELS) (min 1)  channel index for load.
REQ-012 load_value  input  WIDTH  value written on load.
REQ-013 count  output  CHANNELS x WIDTH  registered per-channel count.
REQ-014 at_max  output  CHANNELS  combinational flag, count == MAX_COUNT.
REQ-015 at_zero  output  CHANNELS  combinational flag, count == 0.
REQ-016 ovf  output  CHANNELS  one-cycle registered pulse, increment attempted at MAX_COUNT.
REQ-017 unf  output  CHANNELS  one-cycle registered pulse, decrement attempted at 0.
REQ-018 err_load  output  1  one-cycle registered pulse, rejected load.

Function
REQ-019 Each channel SHALL update once per rising clk edge, independently of all other channels.
REQ-020 Per-channel priority SHALL be: reset > load (selected channel) > inc/dec.
REQ-021 inc=1, dec=0: count < MAX_COUNT -> count+1; count == MAX_COUNT -> 0 (WRAP) or hold MAX_COUNT (SATURATE); ovf=1 next cycle in both modes.
REQ-022 dec=1, inc=0: count > 0 -> count-1; count == 0 -> MAX_COUNT (WRAP) or hold 0 (SATURATE); unf=1 next cycle in both modes.
REQ-023 inc=1 and dec=1 together SHALL hold count; no ovf/unf pulse.
REQ-024 inc=0 and dec=0 SHALL hold count.
REQ-025 load with load_value <= MAX_COUNT and load_ch < CHANNELS SHALL set count[load_ch] = load_value next cycle; inc/dec for that channel that cycle are ignored.
REQ-026 load with load_value > MAX_COUNT or load_ch >= CHANNELS SHALL change no count and SHALL pulse err_load next cycle; inc/dec proceed normally on all channels.
REQ-027 Channels not selected by load SHALL apply their own inc/dec in the same cycle as a load.
REQ-028 All arithmetic SHALL be WIDTH bits unsigned; no intermediate value outside 0..MAX_COUNT SHALL ever be registered.
REQ-029 ovf, unf, err_load SHALL be high for exactly one cycle per causing event and low otherwise.
REQ-030 Latency inc/dec/load to count SHALL be exactly one clock.

Reset
REQ-031 reset=1 at a rising edge SHALL set every count to 0 and ovf, unf, err_load to 0, overriding load/inc/dec that cycle.
REQ-032 After reset, at_zero SHALL be all ones and at_max all zeros (MAX_COUNT >= 1).
REQ-033 Reset asserted mid-sequence SHALL discard all pending requests; counting resumes from 0 on the first edge with reset=0.

Structure
REQ-034 Package updown_counter_pkg SHALL hold the mode enum (WRAP, SATURATE) and the index-width helper constant/function.
REQ-035 Per-channel state SHALL be implemented in sub-module updown_counter_ch (one count register, ovf/unf registers, wrap/saturate logic), instantiated CHANNELS times by a generate loop.
REQ-036 Top level SHALL contain only load decode/validation, err_load register, and flag assembly.

Verification
REQ-037 WIDTH=8, MAX_COUNT=9, WRAP: reset, inc ch0 for 12 cycles -> count[0] 0..9,0,1,2; ovf[0] single pulse after the 10th increment.
REQ-038 Same config, SATURATE: dec ch1 from 0 for 3 cycles -> count[1] stays 0, unf[1] pulses each cycle; inc 15 cycles -> stops at 9, at_max[1]=1.
REQ-039 inc=dec=1 on ch2 at count 5 for 4 cycles -> count[2] stays 5, no ovf/unf.
REQ-040 load ch3 value 7 while inc[3]=1 and inc[0]=1 -> count[3]=7, count[0] increments same cycle.
REQ-041 load value 12 (>9) to ch0 -> count unchanged, err_load one-cycle pulse.
REQ-042 Default parameters: load 32'hFFFF_FFFF to ch0, inc -> count 0 with ovf; reset asserted mid-count -> all counts 0 next edge.

Source files
------------

// File: rtl/updown_counter_mc_pkg.sv
// Shared types and helpers for the multi-channel up/down counter.
package updown_counter_pkg;

    // Overflow policy applied at the terminal values.
    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } mode_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/updown_counter_mc_if.sv
// Request/status bundle between a counter client and updown_counter_mc.
interface updown_counter_mc_if
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int IDX_W = idx_w(CHANNELS);

    logic [CHANNELS-1:0]            inc;
    logic [CHANNELS-1:0]            dec;
    logic                           load;
    logic [IDX_W-1:0]               load_ch;
    logic [WIDTH-1:0]               load_value;
    logic [CHANNELS-1:0][WIDTH-1:0] count;
    logic [CHANNELS-1:0]            at_max;
    logic [CHANNELS-1:0]            at_zero;
    logic [CHANNELS-1:0]            ovf;
    logic [CHANNELS-1:0]            unf;
    logic                           err_load;

    modport master (
        output inc, dec, load, load_ch, load_value,
        input  count, at_max, at_zero, ovf, unf, err_load
    );

    modport slave (
        input  inc, dec, load, load_ch, load_value,
        output count, at_max, at_zero, ovf, unf, err_load
    );

endinterface

// File: rtl/updown_counter_mc_ch.sv
// One counter channel: count register plus ovf/unf pulses, wrap or saturate.
module updown_counter_ch
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter mode_e            MODE      = WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Next state: load beats inc/dec; inc+dec together is a hold.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load_i) begin
            count_d = load_value_i;
        end else if (inc_i && !dec_i) begin
            if (count_q == MAX_COUNT) begin
                ovf_d   = 1'b1;
                count_d = (MODE == WRAP) ? '0 : MAX_COUNT;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                unf_d   = 1'b1;
                count_d = (MODE == WRAP) ? MAX_COUNT : '0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/updown_counter_mc.sv
// Multi-channel up/down counter: load decode/validation, err_load, flags.
module updown_counter_mc
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter mode_e            MODE      = WRAP
) (
    input  logic               clk,
    input  logic               reset,
    updown_counter_mc_if.slave bus
);

    logic                load_ok;
    logic [CHANNELS-1:0] ld_hit;
    logic                err_q, err_d;

    // A load is accepted only for an existing channel and an in-range value.
    assign load_ok = bus.load && (int'(bus.load_ch) < CHANNELS)
                              && (bus.load_value <= MAX_COUNT);
    assign err_d   = bus.load && !load_ok;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign ld_hit[c] = load_ok && (int'(bus.load_ch) == c);

        updown_counter_ch #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .MODE      (MODE)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .inc_i        (bus.inc[c]),
            .dec_i        (bus.dec[c]),
            .load_i       (ld_hit[c]),
            .load_value_i (bus.load_value),
            .count_o      (bus.count[c]),
            .ovf_o        (bus.ovf[c]),
            .unf_o        (bus.unf[c])
        );
    end

    // Rejected-load pulse register.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err_load = err_q;

    // Terminal-value flags decoded from the registered counts.
    always_comb begin
        bus.at_max  = '0;
        bus.at_zero = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.at_max[c]  = (bus.count[c] == MAX_COUNT);
            bus.at_zero[c] = (bus.count[c] == '0);
        end
    end

endmodule

// File: tb/tb_updown_counter_mc.sv
// Directed bench: WRAP and SATURATE at WIDTH=8/MAX=9, plus default parameters.
module tb_updown_counter_mc;
    import updown_counter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    updown_counter_mc_if #(.WIDTH(8),  .CHANNELS(4)) bw ();
    updown_counter_mc_if #(.WIDTH(8),  .CHANNELS(4)) bs ();
    updown_counter_mc_if #(.WIDTH(32), .CHANNELS(4)) bd ();

    updown_counter_mc #(.WIDTH(8), .CHANNELS(4), .MAX_COUNT(8'd9), .MODE(WRAP))
        u_w (.clk(clk), .reset(reset), .bus(bw));
    updown_counter_mc #(.WIDTH(8), .CHANNELS(4), .MAX_COUNT(8'd9), .MODE(SATURATE))
        u_s (.clk(clk), .reset(reset), .bus(bs));
    updown_counter_mc u_d (.clk(clk), .reset(reset), .bus(bd));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        {bw.inc, bw.dec, bw.load, bw.load_ch, bw.load_value} = '0;
        {bs.inc, bs.dec, bs.load, bs.load_ch, bs.load_value} = '0;
        {bd.inc, bd.dec, bd.load, bd.load_ch, bd.load_value} = '0;

        // ---- WRAP, MAX=9 ----
        do_rst();
        chk("w_rst_cnt0", bw.count[0], 0);
        chk("w_rst_zero", bw.at_zero, 4'hF);
        chk("w_rst_max",  bw.at_max, 0);
        chk("w_rst_ovf",  bw.ovf, 0);
        chk("w_rst_err",  bw.err_load, 0);

        bw.inc = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("w_inc_cnt%0d", k), bw.count[0], k % 10);
            chk($sformatf("w_inc_ovf%0d", k), bw.ovf[0], (k == 10));
        end
        bw.inc = '0;
        step();
        chk("w_idle_cnt", bw.count[0], 2);
        chk("w_idle_ovf", bw.ovf, 0);

        bw.load = 1'b1; bw.load_ch = 2'd2; bw.load_value = 8'd5;
        step();
        bw.load = 1'b0;
        chk("w_ld2_cnt", bw.count[2], 5);
        chk("w_ld2_err", bw.err_load, 0);

        bw.inc = 4'b0100; bw.dec = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("w_both_cnt",  bw.count[2], 5);
            chk("w_both_flag", {bw.ovf[2], bw.unf[2]}, 0);
        end

        // load ch3 while ch0/ch3 increment and ch1 underflows
        bw.load = 1'b1; bw.load_ch = 2'd3; bw.load_value = 8'd7;
        bw.inc = 4'b1001; bw.dec = 4'b0010;
        step();
        bw.load = 1'b0; bw.inc = '0; bw.dec = '0;
        chk("w_ld3_cnt3", bw.count[3], 7);
        chk("w_ld3_cnt0", bw.count[0], 3);
        chk("w_ld3_cnt1", bw.count[1], 9);
        chk("w_ld3_unf",  bw.unf, 4'b0010);
        chk("w_ld3_ovf",  bw.ovf, 0);

        bw.load = 1'b1; bw.load_ch = 2'd0; bw.load_value = 8'd12;
        step();
        bw.load = 1'b0;
        chk("w_bad_cnt", bw.count[0], 3);
        chk("w_bad_err", bw.err_load, 1);
        step();
        chk("w_bad_err_clr", bw.err_load, 0);

        bw.load = 1'b1; bw.load_ch = 2'd0; bw.load_value = 8'd9;
        step();
        bw.load = 1'b0;
        chk("w_ldmax_cnt", bw.count[0], 9);
        chk("w_ldmax_err", bw.err_load, 0);
        chk("w_ldmax_flg", bw.at_max, 4'b0011);

        // ---- SATURATE, MAX=9 ----
        do_rst();
        bs.dec = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s_dec_cnt", bs.count[1], 0);
            chk("s_dec_unf", bs.unf, 4'b0010);
        end
        bs.dec = '0; bs.inc = 4'b0010;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("s_inc_cnt%0d", k), bs.count[1], (k > 9) ? 9 : k);
            chk($sformatf("s_inc_ovf%0d", k), bs.ovf[1], (k >= 10));
        end
        chk("s_atmax", bs.at_max, 4'b0010);
        bs.inc = '0;
        step();
        chk("s_hold_cnt", bs.count[1], 9);
        chk("s_hold_ovf", bs.ovf, 0);

        // ---- default parameters ----
        do_rst();
        bd.load = 1'b1; bd.load_ch = 2'd0; bd.load_value = 32'hFFFF_FFFF;
        step();
        bd.load = 1'b0;
        chk("d_ld_cnt", bd.count[0], 64'hFFFF_FFFF);
        chk("d_ld_max", bd.at_max, 4'b0001);
        bd.inc = 4'b0011;
        step();
        chk("d_wrap_cnt", bd.count[0], 0);
        chk("d_wrap_ovf", bd.ovf, 4'b0001);
        chk("d_cnt1",     bd.count[1], 1);
        step();
        step();
        chk("d_mid_cnt0", bd.count[0], 2);
        chk("d_mid_cnt1", bd.count[1], 3);
        reset = 1'b1;
        step();
        for (int c = 0; c < 4; c++) chk($sformatf("d_rst_cnt%0d", c), bd.count[c], 0);
        chk("d_rst_zero", bd.at_zero, 4'hF);
        chk("d_rst_ovf",  bd.ovf, 0);
        reset = 1'b0;
        step();
        chk("d_resume0", bd.count[0], 1);
        chk("d_resume1", bd.count[1], 1);
        bd.inc = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
